// File: rtl/ins_encoder.sv
// ins_encoder: packs decoded RV32I fields into 32-bit instruction words,
// checks that the immediate fits the target format, and streams each word
// with its instruction-memory byte address over a valid/ready interface.
module ins_encoder #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int STOP_ON_ERR = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [6:0]        i_opcode,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [2:0]        i_funct3,
  input  logic [6:0]        i_funct7,
  input  logic [31:0]       i_imm,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_ins,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_err,
  output logic [1:0]        o_err_code,
  output logic              o_done,
  output logic              o_halt
);

  // Word counter is wide enough to hold DEPTH itself.
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_MISAL = 2'b10;
  localparam logic [1:0] ERR_UNSUP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10,
    ST_HALT = 2'b11
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [CNT_W-1:0]    count_r;
  logic                valid_r;
  logic [31:0]         ins_r;
  logic [ADDR_W-1:0]   out_addr_r;
  logic [1:0]          code_r;
  logic                err_r;
  logic                done_r;
  logic                halt_r;

  logic [31:0]         enc_ins_s;
  logic [1:0]          enc_code_s;
  logic                ready_s;
  logic                accept_s;
  logic [ADDR_W-1:0]   base_aligned_s;

  // Signed 12-bit immediate: bits [31:11] must all match the sign.
  function automatic logic fits_i12(input logic [31:0] v);
    return (v[31:11] == {21{1'b0}}) || (v[31:11] == {21{1'b1}});
  endfunction

  // Signed 13-bit branch offset: bits [31:12] must all match the sign.
  function automatic logic fits_b13(input logic [31:0] v);
    return (v[31:12] == {20{1'b0}}) || (v[31:12] == {20{1'b1}});
  endfunction

  // Signed 21-bit jump offset: bits [31:20] must all match the sign.
  function automatic logic fits_j21(input logic [31:0] v);
    return (v[31:20] == {12{1'b0}}) || (v[31:20] == {12{1'b1}});
  endfunction

  // Unsigned 5-bit shift amount.
  function automatic logic fits_sh5(input logic [31:0] v);
    return (v[31:5] == {27{1'b0}});
  endfunction

  assign base_aligned_s = i_base_addr & ~ADDR_W'(3);
  assign ready_s        = (state_r == ST_RUN) && (!valid_r || i_ready) && !i_start;
  assign accept_s       = i_valid && ready_s;

  assign o_ready    = ready_s;
  assign o_valid    = valid_r;
  assign o_ins      = ins_r;
  assign o_addr     = out_addr_r;
  assign o_err      = err_r;
  assign o_err_code = code_r;
  assign o_done     = done_r;
  assign o_halt     = halt_r;

  // Field packing and immediate checks; misalignment outranks range.
  always_comb begin
    enc_ins_s  = 32'd0;
    enc_code_s = ERR_NONE;
    case (i_opcode)
      OP_REG: begin
        enc_ins_s  = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
        enc_code_s = ERR_NONE;
      end
      OP_LOAD, OP_JALR: begin
        enc_ins_s = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        if (fits_i12(i_imm)) enc_code_s = ERR_NONE;
        else                 enc_code_s = ERR_RANGE;
      end
      OP_IMM: begin
        if ((i_funct3 == 3'b001) || (i_funct3 == 3'b101)) begin
          enc_ins_s = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, i_opcode};
          if (fits_sh5(i_imm)) enc_code_s = ERR_NONE;
          else                 enc_code_s = ERR_RANGE;
        end else begin
          enc_ins_s = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
          if (fits_i12(i_imm)) enc_code_s = ERR_NONE;
          else                 enc_code_s = ERR_RANGE;
        end
      end
      OP_STORE: begin
        enc_ins_s = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        if (fits_i12(i_imm)) enc_code_s = ERR_NONE;
        else                 enc_code_s = ERR_RANGE;
      end
      OP_BRANCH: begin
        enc_ins_s = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                     i_imm[4:1], i_imm[11], i_opcode};
        if (i_imm[0])               enc_code_s = ERR_MISAL;
        else if (!fits_b13(i_imm))  enc_code_s = ERR_RANGE;
        else                        enc_code_s = ERR_NONE;
      end
      OP_LUI, OP_AUIPC: begin
        enc_ins_s = {i_imm[31:12], i_rd, i_opcode};
        if (i_imm[11:0] != 12'd0) enc_code_s = ERR_MISAL;
        else                      enc_code_s = ERR_NONE;
      end
      OP_JAL: begin
        enc_ins_s = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        if (i_imm[0])               enc_code_s = ERR_MISAL;
        else if (!fits_j21(i_imm))  enc_code_s = ERR_RANGE;
        else                        enc_code_s = ERR_NONE;
      end
      default: begin
        enc_ins_s  = 32'd0;
        enc_code_s = ERR_UNSUP;
      end
    endcase
  end

  // Control FSM, address/count tracking and the registered output stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= ST_IDLE;
      addr_r     <= '0;
      count_r    <= '0;
      valid_r    <= 1'b0;
      ins_r      <= 32'd0;
      out_addr_r <= '0;
      code_r     <= ERR_NONE;
      err_r      <= 1'b0;
      done_r     <= 1'b0;
      halt_r     <= 1'b0;
    end else if (i_start) begin
      // A restart drops any beat still waiting downstream.
      state_r <= ST_RUN;
      addr_r  <= base_aligned_s;
      count_r <= '0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      halt_r  <= 1'b0;
    end else if (accept_s) begin
      valid_r    <= 1'b1;
      ins_r      <= enc_ins_s;
      out_addr_r <= addr_r;
      code_r     <= enc_code_s;
      err_r      <= (enc_code_s != ERR_NONE);
      addr_r     <= addr_r + ADDR_W'(4);
      count_r    <= count_r + CNT_W'(1);
      if ((STOP_ON_ERR != 0) && (enc_code_s != ERR_NONE)) begin
        state_r <= ST_HALT;
        halt_r  <= 1'b1;
      end else if (count_r == LAST_CNT) begin
        state_r <= ST_DONE;
        done_r  <= 1'b1;
      end else begin
        state_r <= ST_RUN;
      end
    end else if (valid_r && i_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

endmodule

// File: tb/tb_ins_encoder.sv
// tb_ins_encoder: directed and randomized checks of ins_encoder against a
// behavioural reference encoder and a transaction-level stream model.
module tb_ins_encoder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Shared instruction fields
  logic [6:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm;

  // Instance A: DEPTH 1024, keeps running on errors
  logic        rst_a, start_a, valid_a, rdy_a;
  logic [31:0] base_a;
  logic        ordy_a, ov_a, oerr_a, odone_a, ohalt_a;
  logic [31:0] oins_a, oaddr_a;
  logic [1:0]  ocode_a;

  // Instance B: DEPTH 4, halts on errors
  logic        rst_b, start_b, valid_b, rdy_b;
  logic [31:0] base_b;
  logic        ordy_b, ov_b, oerr_b, odone_b, ohalt_b;
  logic [31:0] oins_b, oaddr_b;
  logic [1:0]  ocode_b;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  ins_encoder #(.ADDR_W(32), .DEPTH(1024), .STOP_ON_ERR(0)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_start(start_a), .i_base_addr(base_a),
    .i_valid(valid_a), .o_ready(ordy_a), .i_opcode(op), .i_rd(rd),
    .i_rs1(rs1), .i_rs2(rs2), .i_funct3(f3), .i_funct7(f7), .i_imm(imm),
    .o_valid(ov_a), .i_ready(rdy_a), .o_ins(oins_a), .o_addr(oaddr_a),
    .o_err(oerr_a), .o_err_code(ocode_a), .o_done(odone_a), .o_halt(ohalt_a));

  ins_encoder #(.ADDR_W(32), .DEPTH(4), .STOP_ON_ERR(1)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_start(start_b), .i_base_addr(base_b),
    .i_valid(valid_b), .o_ready(ordy_b), .i_opcode(op), .i_rd(rd),
    .i_rs1(rs1), .i_rs2(rs2), .i_funct3(f3), .i_funct7(f7), .i_imm(imm),
    .o_valid(ov_b), .i_ready(rdy_b), .o_ins(oins_b), .o_addr(oaddr_b),
    .o_err(oerr_b), .o_err_code(ocode_b), .o_done(odone_b), .o_halt(ohalt_b));

  logic [6:0] op_tab [0:9] = '{7'h33, 7'h03, 7'h67, 7'h13, 7'h23,
                               7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
  int imm_tab [0:19] = '{-4097, -4096, -4095, -2049, -2048, 2047, 2048,
                         4094, 4095, 4096, 1048574, 1048575, 1048576,
                         -1048576, -1048577, 31, 32, 4096, 4097, 0};

  // Reference encoder written directly from the instruction formats.
  function automatic logic [33:0] ref_enc(input logic [6:0] o, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] fn3,
      input logic [6:0] fn7, input logic [31:0] im);
    longint v;
    logic [31:0] w;
    logic [1:0] c;
    v = longint'($signed(im));
    w = 32'd0;
    c = 2'd0;
    case (o)
      7'h33: w = {fn7, s2, s1, fn3, d, o};
      7'h03, 7'h67, 7'h13: begin
        if (o == 7'h13 && (fn3 == 3'd1 || fn3 == 3'd5)) begin
          w = {fn7, im[4:0], s1, fn3, d, o};
          if (im > 32'd31) c = 2'd1;
        end else begin
          w = {im[11:0], s1, fn3, d, o};
          if (v < -2048 || v > 2047) c = 2'd1;
        end
      end
      7'h23: begin
        w = {im[11:5], s2, s1, fn3, im[4:0], o};
        if (v < -2048 || v > 2047) c = 2'd1;
      end
      7'h63: begin
        w = {im[12], im[10:5], s2, s1, fn3, im[4:1], im[11], o};
        if (im[0]) c = 2'd2;
        else if (v < -4096 || v > 4094) c = 2'd1;
      end
      7'h37, 7'h17: begin
        w = {im[31:12], d, o};
        if ((im % 32'd4096) != 32'd0) c = 2'd2;
      end
      7'h6F: begin
        w = {im[20], im[10:1], im[11], im[19:12], d, o};
        if (im[0]) c = 2'd2;
        else if (v < -1048576 || v > 1048574) c = 2'd1;
      end
      default: c = 2'd3;
    endcase
    return {c, w};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic v, input logic [31:0] ins,
      input logic [31:0] ad, input logic e, input logic [1:0] c,
      input logic [31:0] x_ins, input logic [31:0] x_ad, input logic [1:0] x_c);
    chk({tag, "_valid"}, 64'(v), 64'd1);
    chk({tag, "_ins"}, 64'(ins), 64'(x_ins));
    chk({tag, "_addr"}, 64'(ad), 64'(x_ad));
    chk({tag, "_code"}, 64'(c), 64'(x_c));
    chk({tag, "_err"}, 64'(e), 64'(x_c != 2'd0));
  endtask

  task automatic set_f(input logic [6:0] o, input logic [4:0] d, input logic [4:0] s1,
      input logic [4:0] s2, input logic [2:0] fn3, input logic [6:0] fn7,
      input logic [31:0] im);
    op = o; rd = d; rs1 = s1; rs2 = s2; f3 = fn3; f7 = fn7; imm = im;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [33:0] pend;
  logic        m_ov, m_acc, m_rdy;
  logic [31:0] m_ins, m_addr, m_nxt;
  logic [1:0]  m_code;

  initial begin
    rst_a = 1'b1; start_a = 1'b0; valid_a = 1'b0; rdy_a = 1'b0; base_a = 32'd0;
    rst_b = 1'b1; start_b = 1'b0; valid_b = 1'b0; rdy_b = 1'b0; base_b = 32'd0;
    set_f(7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    tick(); tick();
    rst_a = 1'b0; rst_b = 1'b0;

    // Reset state
    chk("rst_valid", 64'(ov_a), 64'd0);
    chk("rst_ins", 64'(oins_a), 64'd0);
    chk("rst_addr", 64'(oaddr_a), 64'd0);
    chk("rst_err", 64'({oerr_a, ocode_a}), 64'd0);
    chk("rst_done_halt", 64'({odone_a, ohalt_a}), 64'd0);
    chk("rst_ready", 64'(ordy_a), 64'd0);

    // Basic stream at 0x100
    start_a = 1'b1; base_a = 32'h100;
    tick();
    start_a = 1'b0; rdy_a = 1'b1; valid_a = 1'b1;
    set_f(7'h13, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    #1 chk("t1_ready", 64'(ordy_a), 64'd1);
    tick();
    chk_beat("t1_addi", ov_a, oins_a, oaddr_a, oerr_a, ocode_a, 32'hFFF08113, 32'h100, 2'd0);
    set_f(7'h63, 5'd0, 5'd3, 5'd4, 3'd0, 7'd0, 32'hFFFF_FFF8);
    tick();
    chk_beat("t1_beq", ov_a, oins_a, oaddr_a, oerr_a, ocode_a, 32'hFE418CE3, 32'h104, 2'd0);
    set_f(7'h37, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1000);
    tick();
    chk_beat("t1_lui", ov_a, oins_a, oaddr_a, oerr_a, ocode_a, 32'h00001137, 32'h108, 2'd0);
    set_f(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    tick();
    chk_beat("t1_jal", ov_a, oins_a, oaddr_a, oerr_a, ocode_a, 32'h001000EF, 32'h10C, 2'd0);
    valid_a = 1'b0;
    tick();
    chk("t1_drain", 64'(ov_a), 64'd0);

    // Backpressure: output held, second beat waits
    rdy_a = 1'b0; valid_a = 1'b1;
    set_f(7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd100);
    tick();
    chk_beat("t2_first", ov_a, oins_a, oaddr_a, oerr_a, ocode_a, 32'h06400293, 32'h110, 2'd0);
    set_f(7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'hFFFF_FFFC);
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("t2_ready_%0d", i), 64'(ordy_a), 64'd0);
      tick();
      chk_beat($sformatf("t2_hold_%0d", i), ov_a, oins_a, oaddr_a, oerr_a, ocode_a,
               32'h06400293, 32'h110, 2'd0);
    end
    rdy_a = 1'b1;
    #1 chk("t2_ready_rel", 64'(ordy_a), 64'd1);
    tick();
    chk_beat("t2_second", ov_a, oins_a, oaddr_a, oerr_a, ocode_a, 32'hFE512E23, 32'h114, 2'd0);
    valid_a = 1'b0;
    tick();
    chk("t2_drain", 64'(ov_a), 64'd0);

    // Error codes, no halt on this instance
    valid_a = 1'b1;
    set_f(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    tick();
    chk_beat("t3_range", ov_a, oins_a, oaddr_a, oerr_a, ocode_a, 32'h80000093, 32'h118, 2'd1);
    set_f(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    #1 chk("t3_still_run", 64'({ordy_a, ohalt_a}), 64'b10);
    tick();
    chk_beat("t3_misal", ov_a, oins_a, oaddr_a, oerr_a, ocode_a, 32'h00208163, 32'h11C, 2'd2);
    set_f(7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    tick();
    chk_beat("t3_unsup", ov_a, oins_a, oaddr_a, oerr_a, ocode_a, 32'h0, 32'h120, 2'd3);
    valid_a = 1'b0;
    tick();
    chk("t3_drain", 64'(ov_a), 64'd0);

    // Randomized stream near the top of the address space (wraps)
    start_a = 1'b1;
    base_a = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
    m_nxt = base_a & ~32'd3;
    m_ov = 1'b0; m_ins = 32'd0; m_addr = 32'd0; m_code = 2'd0;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 300; i++) begin
      begin
        int k;
        k = int'($urandom_range(0, 10));
        if (k == 10) op = 7'($urandom);
        else op = op_tab[k];
      end
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      f3 = 3'($urandom); f7 = 7'($urandom);
      case ($urandom_range(0, 3))
        0: imm = 32'(imm_tab[$urandom_range(0, 19)]);
        1: imm = 32'(int'($urandom_range(0, 8191)) - 4096);
        2: imm = 32'($urandom_range(0, 63)) << 12;
        default: imm = $urandom;
      endcase
      valid_a = ($urandom_range(0, 3) != 0);
      rdy_a = ($urandom_range(0, 2) != 0);
      m_rdy = !m_ov || rdy_a;
      m_acc = valid_a && m_rdy;
      pend = ref_enc(op, rd, rs1, rs2, f3, f7, imm);
      #1 chk($sformatf("rnd_ready_%0d", i), 64'(ordy_a), 64'(m_rdy));
      tick();
      if (m_acc) begin
        m_ov = 1'b1; m_ins = pend[31:0]; m_code = pend[33:32];
        m_addr = m_nxt; m_nxt = m_nxt + 32'd4;
      end else if (m_ov && rdy_a) begin
        m_ov = 1'b0;
      end
      chk($sformatf("rnd_valid_%0d", i), 64'(ov_a), 64'(m_ov));
      if (m_ov)
        chk_beat($sformatf("rnd_%0d", i), ov_a, oins_a, oaddr_a, oerr_a, ocode_a,
                 m_ins, m_addr, m_code);
    end
    valid_a = 1'b0; rdy_a = 1'b1;
    tick();

    // Restart while a beat is pending downstream, then reset mid-stream
    rdy_a = 1'b0; valid_a = 1'b1;
    set_f(7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd100);
    tick();
    chk("t6_pending", 64'(ov_a), 64'd1);
    start_a = 1'b1; base_a = 32'h302;
    #1 chk("t6_start_blocks", 64'(ordy_a), 64'd0);
    tick();
    start_a = 1'b0;
    chk("t6_dropped", 64'(ov_a), 64'd0);
    rdy_a = 1'b1;
    tick();
    chk_beat("t6_reload", ov_a, oins_a, oaddr_a, oerr_a, ocode_a, 32'h06400293, 32'h300, 2'd0);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    chk("t6_rst_out", 64'({ov_a, oerr_a, ocode_a, odone_a, ohalt_a}), 64'd0);
    chk("t6_rst_ins_addr", {oins_a, oaddr_a}, 64'd0);
    #1 chk("t6_rst_idle", 64'(ordy_a), 64'd0);
    tick();
    chk("t6_idle_noacc", 64'({ov_a, ordy_a}), 64'd0);
    valid_a = 1'b0;

    // Halt on error (instance B)
    start_b = 1'b1; base_b = 32'h200;
    tick();
    start_b = 1'b0; rdy_b = 1'b1; valid_b = 1'b1;
    set_f(7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd100);
    tick();
    chk_beat("t4_ok", ov_b, oins_b, oaddr_b, oerr_b, ocode_b, 32'h06400293, 32'h200, 2'd0);
    set_f(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F7FF);
    tick();
    chk_beat("t4_err", ov_b, oins_b, oaddr_b, oerr_b, ocode_b, 32'h7FF00093, 32'h204, 2'd1);
    chk("t4_halt", 64'({ohalt_b, odone_b}), 64'b10);
    #1 chk("t4_halt_ready", 64'(ordy_b), 64'd0);
    tick();
    chk("t4_drained", 64'({ov_b, ohalt_b}), 64'b01);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    set_f(7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd100);
    chk("t4_restart_halt", 64'(ohalt_b), 64'd0);
    #1 chk("t4_restart_ready", 64'(ordy_b), 64'd1);

    // DEPTH limit: six beats offered, four accepted
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i < 4)
        chk_beat($sformatf("t5_beat_%0d", i), ov_b, oins_b, oaddr_b, oerr_b, ocode_b,
                 32'h06400293, 32'h200 + 32'(4 * i), 2'd0);
      else
        chk($sformatf("t5_noacc_%0d", i), 64'({ov_b, odone_b}), 64'b01);
      if (i == 3) begin
        chk("t5_done", 64'(odone_b), 64'd1);
        #1 chk("t5_done_ready", 64'(ordy_b), 64'd0);
      end
    end
    valid_b = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
